// File: rtl/ahb_flash_arbiter.sv
// ahb_flash_arbiter: two-master AHB-lite arbiter in front of the flash writer.
// Define ARB_LOCK_EN to add M0_HLOCK/M1_HLOCK bus locking.
module ahb_flash_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic        HCLK,
  input  logic        RST,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
`ifdef ARB_LOCK_EN
  input  logic        M0_HLOCK,
  input  logic        M1_HLOCK,
`endif
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d, oth_state;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_sum;
  logic          dp_valid_q, dp_owner_q;
  logic          req0, req1, own_sel, own_req, oth_req;
  logic          acc, at_lim, lock, grant0, grant1;

  assign req0      = M0_HTRANS[1];
  assign req1      = M1_HTRANS[1];
  assign own_sel   = (state_q == OWN1);
  assign own_req   = own_sel ? req1 : req0;
  assign oth_req   = own_sel ? req0 : req1;
  assign oth_state = own_sel ? OWN0 : OWN1;
  assign grant0    = req0 && (!req1 || !rr_q);
  assign grant1    = req1 && (!req0 || rr_q);

  // The limit counts the phase being accepted on this edge, so the
  // owner gets exactly HOLD_MAX address phases before a forced handover.
  assign acc     = S_HREADYOUT && (state_q != IDLE) && own_req;
  assign cnt_sum = {1'b0, cnt_q} + (CW+1)'(acc);
  assign at_lim  = cnt_sum >= (CW+1)'(HOLD_MAX);

`ifdef ARB_LOCK_EN
  assign lock = (state_q == OWN0 && M0_HLOCK) ||
                (state_q == OWN1 && M1_HLOCK);
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (S_HREADYOUT) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            grant0:  state_d = OWN0;
            grant1:  state_d = OWN1;
            default: state_d = IDLE;
          endcase
        end
        OWN0, OWN1: begin
          if (!lock) begin
            if (!own_req)
              state_d = oth_req ? oth_state : IDLE;
            else if (at_lim && oth_req)
              state_d = oth_state;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
        cnt_d = '0;
        rr_d  = (state_d == OWN0) ||
                (state_d == IDLE && state_q == OWN0);
      end else if (acc) begin
        cnt_d = at_lim ? CW'(HOLD_MAX) : cnt_sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (S_HREADYOUT) begin
        dp_valid_q <= S_HTRANS[1];
        dp_owner_q <= own_sel;
      end
    end
  end

  always_comb begin
    S_HADDR  = M0_HADDR;
    S_HWRITE = M0_HWRITE;
    S_HSIZE  = M0_HSIZE;
    S_HTRANS = 2'b00;
    if (!RST) begin
      unique case (state_q)
        OWN0: S_HTRANS = M0_HTRANS;
        OWN1: begin
          S_HADDR  = M1_HADDR;
          S_HWRITE = M1_HWRITE;
          S_HSIZE  = M1_HSIZE;
          S_HTRANS = M1_HTRANS;
        end
        default: S_HTRANS = 2'b00;
      endcase
    end
  end

  assign S_HWDATA = (!RST && dp_valid_q && dp_owner_q) ? M1_HWDATA
                                                      : M0_HWDATA;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  always_comb begin
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;
    if (!RST) begin
      if (state_q == OWN0 || (dp_valid_q && !dp_owner_q))
        M0_HREADY = S_HREADYOUT;
      else if (req0)
        M0_HREADY = 1'b0;
      if (state_q == OWN1 || (dp_valid_q && dp_owner_q))
        M1_HREADY = S_HREADYOUT;
      else if (req1)
        M1_HREADY = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_flash_arbiter.sv
// tb_ahb_flash_arbiter: directed stimulus with a queue-based scoreboard.
// Define ARB_LOCK_EN to also exercise the HLOCK scenario.
module tb_ahb_flash_arbiter;

  localparam logic [1:0] T_IDL = 2'b00;
  localparam logic [1:0] T_BSY = 2'b01;
  localparam logic [1:0] T_NSQ = 2'b10;
  localparam logic [1:0] T_SEQ = 2'b11;

  localparam int SG_ADDR = 0;
  localparam int SG_TRN  = 1;
  localparam int SG_WD   = 2;
  localparam int SG_RDY0 = 3;
  localparam int SG_RDY1 = 4;
  localparam int SG_RD0  = 5;
  localparam int SG_RD1  = 6;
  localparam int SG_WR   = 7;

  logic        HCLK = 1'b0;
  logic        RST;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HREADYOUT;
  logic [2:0]  S_HSIZE;
`ifdef ARB_LOCK_EN
  logic        M0_HLOCK, M1_HLOCK;
`endif

  ahb_flash_arbiter #(.HOLD_MAX(16)) dut (
    .HCLK(HCLK), .RST(RST),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
`ifdef ARB_LOCK_EN
    .M0_HLOCK(M0_HLOCK), .M1_HLOCK(M1_HLOCK),
`endif
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic [31:0] got;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] sample(input int s);
    logic [31:0] v;
    v = '0;
    case (s)
      SG_ADDR: v = S_HADDR;
      SG_TRN:  v = {30'b0, S_HTRANS};
      SG_WD:   v = S_HWDATA;
      SG_RDY0: v = {31'b0, M0_HREADY};
      SG_RDY1: v = {31'b0, M1_HREADY};
      SG_RD0:  v = M0_HRDATA;
      SG_RD1:  v = M1_HRDATA;
      SG_WR:   v = {31'b0, S_HWRITE};
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(negedge HCLK) begin
    while (sbq.size() > 0) begin
      cur = sbq.pop_front();
      got = sample(cur.sig);
      checks++;
      if (got !== cur.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", cur.tag, got, cur.val);
      end
    end
  end

  task automatic chk(input logic [31:0] g, input logic [31:0] e,
                     input string t);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", t, g, e);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ex(input int s, input logic [31:0] v, input string t);
    exp_t e;
    e.sig = s;
    e.val = v;
    e.tag = t;
    sbq.push_back(e);
  endtask

  task automatic ex_ctl(input string t, input logic [1:0] tr,
                        input logic r0, input logic r1);
    ex(SG_TRN, {30'b0, tr}, {t, ".htrans"});
    ex(SG_RDY0, {31'b0, r0}, {t, ".m0_hready"});
    ex(SG_RDY1, {31'b0, r1}, {t, ".m1_hready"});
  endtask

  task automatic m0(input logic [1:0] t, input logic [31:0] a,
                    input logic w, input logic [31:0] d);
    M0_HTRANS = t;
    M0_HADDR  = a;
    M0_HWRITE = w;
    M0_HWDATA = d;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a,
                    input logic w, input logic [31:0] d);
    M1_HTRANS = t;
    M1_HADDR  = a;
    M1_HWRITE = w;
    M1_HWDATA = d;
  endtask

  task automatic do_reset(input string t);
    RST = 1'b1;
    m0(T_IDL, 32'h0, 1'b0, 32'h0);
    m1(T_IDL, 32'h0, 1'b0, 32'h0);
    ex_ctl(t, T_IDL, 1'b1, 1'b1);
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    S_HREADYOUT = 1'b1;
    S_HRDATA = 32'h0;
    M0_HSIZE = 3'b010;
    M1_HSIZE = 3'b010;
`ifdef ARB_LOCK_EN
    M0_HLOCK = 1'b0;
    M1_HLOCK = 1'b0;
`endif
    m0(T_IDL, 32'h1234, 1'b0, 32'h0BAD_F00D);
    m1(T_NSQ, 32'h9999, 1'b0, 32'h0);
    tick();

    ex_ctl("rst", T_IDL, 1'b1, 1'b1);
    ex(SG_ADDR, 32'h1234, "rst.haddr");
    ex(SG_WD, 32'h0BAD_F00D, "rst.hwdata");
    #1;
    chk({30'b0, S_HTRANS}, 32'h0, "rst.now.htrans");
    chk({31'b0, M0_HREADY}, 32'h1, "rst.now.m0_hready");
    chk({31'b0, M1_HREADY}, 32'h1, "rst.now.m1_hready");
    tick();
    RST = 1'b0;

    m1(T_IDL, 32'h0, 1'b0, 32'h0);
    m0(T_NSQ, 32'h10, 1'b1, 32'h0);
    ex_ctl("A1", T_IDL, 1'b0, 1'b1);
    tick();
    ex(SG_ADDR, 32'h10, "A2.haddr");
    ex(SG_WR, 32'h1, "A2.hwrite");
    ex_ctl("A2", T_NSQ, 1'b1, 1'b1);
    tick();
    m0(T_IDL, 32'h10, 1'b1, 32'hA5A5_A5A5);
    ex(SG_WD, 32'hA5A5_A5A5, "A3.hwdata");
    ex_ctl("A3", T_IDL, 1'b1, 1'b1);
    tick();
    ex_ctl("A4", T_IDL, 1'b1, 1'b1);
    tick();

    do_reset("B.rst");
    m0(T_NSQ, 32'h100, 1'b0, 32'h0);
    m1(T_NSQ, 32'h200, 1'b1, 32'h0);
    ex_ctl("B1", T_IDL, 1'b0, 1'b0);
    tick();
    ex(SG_ADDR, 32'h100, "B2.haddr");
    ex(SG_WR, 32'h0, "B2.hwrite");
    ex_ctl("B2", T_NSQ, 1'b1, 1'b0);
    tick();
    m0(T_BSY, 32'h104, 1'b0, 32'h0);
    S_HRDATA = 32'hDEAD_0001;
    ex(SG_RD0, 32'hDEAD_0001, "B3.m0_hrdata");
    ex(SG_RD1, 32'hDEAD_0001, "B3.m1_hrdata");
    ex_ctl("B3", T_BSY, 1'b1, 1'b0);
    tick();
    ex(SG_ADDR, 32'h200, "B4.haddr");
    ex(SG_WR, 32'h1, "B4.hwrite");
    ex_ctl("B4", T_NSQ, 1'b1, 1'b1);
    tick();
    m0(T_IDL, 32'h0, 1'b0, 32'h0);
    m1(T_IDL, 32'h200, 1'b1, 32'h1111_1111);
    ex(SG_WD, 32'h1111_1111, "B5.hwdata");
    ex_ctl("B5", T_IDL, 1'b1, 1'b1);
    tick();

    m0(T_NSQ, 32'h1000, 1'b0, 32'h0);
    m1(T_NSQ, 32'h2000, 1'b0, 32'h0);
    ex_ctl("C0", T_IDL, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      m0((k == 0) ? T_NSQ : T_SEQ, 32'h1000 + 32'(4 * k), 1'b0, 32'h0);
      ex(SG_ADDR, 32'h1000 + 32'(4 * k), $sformatf("C.m0_addr%0d", k));
      ex_ctl($sformatf("C.m0_%0d", k), (k == 0) ? T_NSQ : T_SEQ,
             1'b1, 1'b0);
      tick();
    end
    m0(T_SEQ, 32'h1040, 1'b0, 32'h0);
    ex(SG_ADDR, 32'h2000, "C17.haddr");
    ex_ctl("C17", T_NSQ, 1'b1, 1'b1);
    tick();
    m1(T_IDL, 32'h2000, 1'b0, 32'h0);
    S_HRDATA = 32'h2000_0DA7;
    ex(SG_RD1, 32'h2000_0DA7, "C18.m1_hrdata");
    ex_ctl("C18", T_IDL, 1'b0, 1'b1);
    tick();
    for (int k = 16; k < 40; k++) begin
      m0(T_SEQ, 32'h1000 + 32'(4 * k), 1'b0, 32'h0);
      ex(SG_ADDR, 32'h1000 + 32'(4 * k), $sformatf("C.m0_addr%0d", k));
      ex_ctl($sformatf("C.m0_%0d", k), T_SEQ, 1'b1, 1'b1);
      tick();
    end
    m0(T_IDL, 32'h0, 1'b0, 32'h0);
    ex_ctl("C43", T_IDL, 1'b1, 1'b1);
    tick();

    m0(T_NSQ, 32'h3000, 1'b0, 32'h0);
    ex_ctl("D0", T_IDL, 1'b0, 1'b1);
    tick();
    m1(T_NSQ, 32'h4000, 1'b1, 32'h0);
    ex(SG_ADDR, 32'h3000, "D1.haddr");
    ex_ctl("D1", T_NSQ, 1'b1, 1'b0);
    tick();
    m0(T_IDL, 32'h3000, 1'b0, 32'h0);
    S_HREADYOUT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_ctl($sformatf("D.wait%0d", k), T_IDL, 1'b0, 1'b0);
      #1;
      chk({31'b0, M0_HREADY}, 32'h0, $sformatf("D.now.wait%0d", k));
      tick();
    end
    S_HREADYOUT = 1'b1;
    S_HRDATA = 32'hCAFE_3000;
    ex(SG_RD0, 32'hCAFE_3000, "D5.m0_hrdata");
    ex_ctl("D5", T_IDL, 1'b1, 1'b0);
    #1;
    chk({31'b0, M0_HREADY}, 32'h1, "D5.now.m0_hready");
    tick();
    ex(SG_ADDR, 32'h4000, "D6.haddr");
    ex(SG_WR, 32'h1, "D6.hwrite");
    ex_ctl("D6", T_NSQ, 1'b1, 1'b1);
    tick();
    m1(T_IDL, 32'h4000, 1'b1, 32'h55AA_55AA);
    ex(SG_WD, 32'h55AA_55AA, "D7.hwdata");
    ex_ctl("D7", T_IDL, 1'b1, 1'b1);
    tick();

    m1(T_NSQ, 32'h5000, 1'b1, 32'h0);
    ex_ctl("E0", T_IDL, 1'b1, 1'b0);
    tick();
    ex(SG_ADDR, 32'h5000, "E1.haddr");
    ex_ctl("E1", T_NSQ, 1'b1, 1'b1);
    tick();
    RST = 1'b1;
    m0(T_IDL, 32'h0, 1'b0, 32'h0BAD_F00D);
    m1(T_IDL, 32'h5000, 1'b1, 32'h7777_7777);
    ex(SG_WD, 32'h0BAD_F00D, "E2.hwdata");
    ex_ctl("E2", T_IDL, 1'b1, 1'b1);
    tick();
    RST = 1'b0;
    ex(SG_WD, 32'h0BAD_F00D, "E3.hwdata");
    ex_ctl("E3", T_IDL, 1'b1, 1'b1);
    tick();
    m1(T_NSQ, 32'h5004, 1'b0, 32'h0);
    ex_ctl("E4", T_IDL, 1'b1, 1'b0);
    tick();
    ex(SG_ADDR, 32'h5004, "E5.haddr");
    ex_ctl("E5", T_NSQ, 1'b1, 1'b1);
    tick();
    m1(T_IDL, 32'h0, 1'b0, 32'h0);
    ex_ctl("E6", T_IDL, 1'b1, 1'b1);
    tick();

`ifdef ARB_LOCK_EN
    do_reset("F.rst");
    M0_HLOCK = 1'b1;
    m0(T_NSQ, 32'h6000, 1'b0, 32'h0);
    m1(T_NSQ, 32'h7000, 1'b0, 32'h0);
    ex_ctl("F0", T_IDL, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      m0((k == 0) ? T_NSQ : T_SEQ, 32'h6000 + 32'(4 * k), 1'b0, 32'h0);
      ex(SG_ADDR, 32'h6000 + 32'(4 * k), $sformatf("F.m0_addr%0d", k));
      ex_ctl($sformatf("F.m0_%0d", k), (k == 0) ? T_NSQ : T_SEQ,
             1'b1, 1'b0);
      tick();
    end
    m0(T_IDL, 32'h0, 1'b0, 32'h0);
    ex_ctl("F21", T_IDL, 1'b1, 1'b0);
    tick();
    M0_HLOCK = 1'b0;
    ex_ctl("F22", T_IDL, 1'b1, 1'b0);
    tick();
    ex(SG_ADDR, 32'h7000, "F23.haddr");
    ex_ctl("F23", T_NSQ, 1'b1, 1'b1);
    tick();
    m1(T_IDL, 32'h0, 1'b0, 32'h0);
    ex_ctl("F24", T_IDL, 1'b1, 1'b1);
    tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
